// File: rtl/hash_session_arbiter_pkg.sv
// Shared types and widths for the hash session arbiter.
package hash_session_arbiter_pkg;

  localparam int DIGEST_W = 64;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    STREAM   = 3'd2,
    DONE     = 3'd3,
    WAIT_DIG = 3'd4,
    RESP     = 3'd5
  } arb_state_t;

endpackage

// File: rtl/hash_session_arbiter_if.sv
// Requester-side bundle: per-source message streams in, grant/response out.
interface hash_session_arbiter_if
  import hash_session_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][BYTE_W-1:0] req_byte;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             resp_valid;
  logic                           resp_err;
  logic [DIGEST_W-1:0]            digest_out;

  // Message sources drive the request side and observe grant/response.
  modport master (
    output req, req_byte, req_valid, req_last,
    input  req_ready, gnt, resp_valid, resp_err, digest_out
  );

  // The arbiter consumes requests and drives grant/response.
  modport slave (
    input  req, req_byte, req_valid, req_last,
    output req_ready, gnt, resp_valid, resp_err, digest_out
  );

endinterface

// File: rtl/hash_session_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last owner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/hash_session_arbiter.sv
// Shares one hash core among NUM_REQ sources, one whole message per grant.
module hash_session_arbiter
  import hash_session_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  hash_session_arbiter_if.slave src,
  output logic                core_start_msg,
  output logic [BYTE_W-1:0]   core_msg_byte,
  output logic                core_valid_in,
  output logic                core_msg_done,
  input  logic                core_load_byte,
  input  logic [DIGEST_W-1:0] core_digest,
  input  logic                core_digest_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  arb_state_t          state;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                rdy_d;
  logic [DIGEST_W-1:0] digest_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                sel_valid;
  logic                sel_last;
  logic [BYTE_W-1:0]   sel_byte;
  logic                xfer;
  logic                dig_rise;
  logic                tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (src.req),
    .ptr       (ptr_q),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  assign sel_valid = src.req_valid[gidx_q];
  assign sel_last  = src.req_last[gidx_q];
  assign sel_byte  = src.req_byte[gidx_q];
  assign xfer      = core_load_byte & sel_valid;
  assign dig_rise  = core_digest_ready & ~rdy_d;
  assign tmo_hit   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Session FSM with grant ownership, rr pointer and digest timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      rdy_d  <= 1'b0;
    end else begin
      rdy_d <= core_digest_ready;
      case (state)
        IDLE: begin
          if (|src.req) begin
            gnt_q  <= arb_gnt;
            gidx_q <= arb_idx;
            ptr_q  <= arb_idx;
            err_q  <= 1'b0;
            state  <= START;
          end
        end
        START: state <= STREAM;
        STREAM: begin
          // A last flag ends the message either with its byte or on its own (no byte).
          if (sel_last && (xfer || !sel_valid)) state <= DONE;
        end
        DONE: begin
          if (core_load_byte) begin
            cnt_q <= '0;
            state <= WAIT_DIG;
          end
        end
        WAIT_DIG: begin
          if (dig_rise) begin
            state <= RESP;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          gnt_q <= '0;
          cnt_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digest capture: core value on a ready rising edge, zero on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      digest_q <= '0;
    end else if (state == WAIT_DIG) begin
      if (dig_rise)     digest_q <= core_digest;
      else if (tmo_hit) digest_q <= '0;
    end
  end

  // Core handshake and per-source strobes decoded from the current state.
  always_comb begin
    core_start_msg = (state == START);
    core_msg_byte  = '0;
    core_valid_in  = 1'b0;
    core_msg_done  = (state == DONE);
    src.req_ready  = '0;
    src.resp_valid = '0;
    if (state == STREAM) begin
      core_msg_byte = sel_byte;
      core_valid_in = sel_valid;
      if (xfer) src.req_ready = gnt_q;
    end
    if (state == RESP) src.resp_valid = gnt_q;
  end

  assign src.gnt        = gnt_q;
  assign src.resp_err   = (state == RESP) & err_q;
  assign src.digest_out = digest_q;

endmodule

// File: tb/tb_hash_session_arbiter.sv
// Directed bench for hash_session_arbiter with a behavioural hash-core stub.
module tb_hash_session_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 16;
  localparam logic [63:0] SEED = 64'h0000_A5A5_811C_9DC5;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_start_msg;
  logic [7:0]  core_msg_byte;
  logic        core_valid_in;
  logic        core_msg_done;
  logic        core_load_byte;
  logic [63:0] core_digest;
  logic        core_digest_ready;

  always #5 clk = ~clk;

  hash_session_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  hash_session_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .src               (bus),
    .core_start_msg    (core_start_msg),
    .core_msg_byte     (core_msg_byte),
    .core_valid_in     (core_valid_in),
    .core_msg_done     (core_msg_done),
    .core_load_byte    (core_load_byte),
    .core_digest       (core_digest),
    .core_digest_ready (core_digest_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Toy digest: {length, xor, sum16, h*31+b}, seeded so an empty message is nonzero.
  function automatic logic [63:0] fold(input logic [63:0] d, input logic [7:0] b);
    logic [7:0]  len, x;
    logic [15:0] s;
    logic [31:0] h;
    {len, x, s, h} = d;
    len = len + 8'd1;
    x   = x ^ b;
    s   = s + {8'h00, b};
    h   = h * 32'd31 + {24'h0, b};
    return {len, x, s, h};
  endfunction

  logic [7:0] msg [0:15];

  function automatic logic [63:0] model_digest(input int n);
    logic [63:0] d;
    d = SEED;
    for (int i = 0; i < n; i++) d = fold(d, msg[i]);
    return d;
  endfunction

  // ---------------- core stub ----------------
  logic        loading, ph, no_ready;
  int          wcnt, rcnt;
  logic [63:0] acc;

  assign core_load_byte    = loading & ph;
  assign core_digest_ready = (rcnt != 0);
  assign core_digest       = core_digest_ready ? acc : 64'h0;

  always @(posedge clk) begin
    if (reset) begin
      loading <= 1'b0;
      ph      <= 1'b0;
      wcnt    <= 0;
      rcnt    <= 0;
      acc     <= SEED;
    end else begin
      ph <= ~ph;
      if (core_start_msg) begin
        loading <= 1'b1;
        acc     <= SEED;
      end else if (loading && ph) begin
        if (core_valid_in) acc <= fold(acc, core_msg_byte);
        if (core_msg_done) begin
          loading <= 1'b0;
          wcnt    <= 3;
        end
      end
      if (rcnt > 0) rcnt <= rcnt - 1;
      if (wcnt > 0) begin
        wcnt <= wcnt - 1;
        if (wcnt == 1 && !no_ready) rcnt <= 2;
      end
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         rdy_cnt [NREQ] = '{default: 0};
  int         start_cnt = 0, done_cnt = 0, resp_cnt = 0, viol = 0;
  int         last_done_cyc = 0, resp_cyc = 0;
  logic [3:0] gq [$];
  logic [3:0] prev_g = 4'h0;

  always @(negedge clk) begin
    #4;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
    if (core_start_msg) start_cnt++;
    if (core_msg_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.resp_valid != 0) begin
      resp_cnt++;
      resp_cyc = cyc;
    end
    if ($countones(bus.gnt) > 1 || (bus.req_ready & ~bus.gnt) != 0 ||
        (bus.resp_valid & ~bus.gnt) != 0) viol++;
    if (bus.gnt != 0 && bus.gnt != prev_g) gq.push_back(bus.gnt);
    prev_g = bus.gnt;
  end

  // ---------------- driver ----------------
  logic [3:0]  r_vec;
  logic        r_err;
  logic [63:0] r_dig;

  task automatic wait_gnt(input int src, input int lim, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      #4;
      if (bus.gnt[src]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int src, input int lim, output bit ok);
    ok = 1'b0;
    r_vec = 4'h0;
    r_err = 1'b0;
    r_dig = 64'h0;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      #4;
      if (bus.resp_valid[src]) begin
        ok    = 1'b1;
        r_vec = bus.resp_valid;
        r_err = bus.resp_err;
        r_dig = bus.digest_out;
        break;
      end
    end
  endtask

  task automatic run_session(input int src, input int n, input int stall_pos, input int stall_len);
    bit ok;
    bit got;
    @(negedge clk);
    bus.req[src] = 1'b1;
    wait_gnt(src, 100, ok);
    check_eq("gnt_seen", 64'(ok), 64'd1);
    if (!ok) begin
      bus.req[src] = 1'b0;
      return;
    end
    @(negedge clk);
    if (n == 0) begin
      bus.req_valid[src] = 1'b0;
      bus.req_last[src]  = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == stall_pos) begin
          bus.req_valid[src] = 1'b0;
          bus.req_last[src]  = 1'b0;
          repeat (stall_len) @(negedge clk);
        end
        bus.req_byte[src]  = msg[i];
        bus.req_valid[src] = 1'b1;
        bus.req_last[src]  = (i == n - 1);
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
          #4;
          if (bus.req_ready[src]) begin
            got = 1'b1;
            break;
          end
          @(negedge clk);
        end
        if (!got) begin
          check_eq("byte_accept", 64'(got), 64'd1);
          break;
        end
        @(negedge clk);
      end
      bus.req_valid[src] = 1'b0;
      bus.req_last[src]  = 1'b0;
    end
    wait_resp(src, 200, ok);
    check_eq("resp_seen", 64'(ok), 64'd1);
    @(negedge clk);
    bus.req[src]       = 1'b0;
    bus.req_valid[src] = 1'b0;
    bus.req_last[src]  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gnt"},   64'(bus.gnt),        64'h0);
    check_eq({tag, "_rdy"},   64'(bus.req_ready),  64'h0);
    check_eq({tag, "_resp"},  64'(bus.resp_valid), 64'h0);
    check_eq({tag, "_err"},   64'(bus.resp_err),   64'h0);
    check_eq({tag, "_dig"},   bus.digest_out,      64'h0);
    check_eq({tag, "_start"}, 64'(core_start_msg), 64'h0);
    check_eq({tag, "_vin"},   64'(core_valid_in),  64'h0);
    check_eq({tag, "_done"},  64'(core_msg_done),  64'h0);
    check_eq({tag, "_byte"},  64'(core_msg_byte),  64'h0);
  endtask

  // ---------------- main sequence ----------------
  int         base, b_rdy, b_st, b_done, b_resp;
  bit         ok;
  logic [3:0] exp_rr [5];
  logic [3:0] gval;

  initial begin
    bus.req       = '0;
    bus.req_byte  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    no_ready      = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Source 0 sends "abc".
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    b_rdy = rdy_cnt[0];
    b_st  = start_cnt;
    run_session(0, 3, -1, 0);
    check_eq("abc_ready_pulses", 64'(rdy_cnt[0] - b_rdy), 64'd3);
    check_eq("abc_start_pulses", 64'(start_cnt - b_st),   64'd1);
    check_eq("abc_resp_vec",     64'(r_vec), 64'h1);
    check_eq("abc_resp_err",     64'(r_err), 64'h0);
    check_eq("abc_digest",       r_dig, model_digest(3));
    check_eq("abc_digest_hi",    64'(r_dig[63:32]), 64'h0360_A6CB);

    // All four request empty messages; grant order follows the pointer.
    exp_rr[0] = 4'b0010; exp_rr[1] = 4'b0100; exp_rr[2] = 4'b1000;
    exp_rr[3] = 4'b0001; exp_rr[4] = 4'b0010;
    base = gq.size();
    @(negedge clk);
    bus.req      = '1;
    bus.req_last = '1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (gq.size() >= base + 5) break;
    end
    check_eq("rr_grant_count", 64'(gq.size() - base), 64'd5);
    for (int k = 0; k < 5; k++) begin
      gval = (base + k < gq.size()) ? gq[base + k] : 4'h0;
      check_eq($sformatf("rr_grant_%0d", k), 64'(gval), 64'(exp_rr[k]));
    end
    wait_resp(1, 200, ok);
    check_eq("rr_last_resp", 64'(ok), 64'd1);
    @(negedge clk);
    bus.req      = '0;
    bus.req_last = '0;
    check_eq("onehot_viol_rr", 64'(viol), 64'd0);

    // Source 2 sends an empty message.
    b_done = done_cnt;
    b_rdy  = rdy_cnt[2];
    run_session(2, 0, -1, 0);
    check_eq("empty_resp_vec", 64'(r_vec), 64'h4);
    check_eq("empty_resp_err", 64'(r_err), 64'h0);
    check_eq("empty_digest",   r_dig, SEED);
    check_eq("empty_msg_done", 64'(done_cnt > b_done), 64'd1);
    check_eq("empty_no_ready", 64'(rdy_cnt[2] - b_rdy), 64'd0);

    // Source 3 session times out while source 0 waits with an empty message.
    msg[0] = 8'h78; msg[1] = 8'h79;
    no_ready = 1'b1;
    @(negedge clk);
    base = gq.size();
    bus.req[3]      = 1'b1;
    bus.req[0]      = 1'b1;
    bus.req_last[0] = 1'b1;
    run_session(3, 2, -1, 0);
    no_ready = 1'b0;
    check_eq("tmo_resp_vec", 64'(r_vec), 64'h8);
    check_eq("tmo_resp_err", 64'(r_err), 64'h1);
    check_eq("tmo_digest",   r_dig, 64'h0);
    check_eq("tmo_latency",  64'(resp_cyc - last_done_cyc), 64'd17);
    wait_resp(0, 200, ok);
    check_eq("after_tmo_resp", 64'(ok), 64'd1);
    check_eq("after_tmo_vec",  64'(r_vec), 64'h1);
    check_eq("after_tmo_err",  64'(r_err), 64'h0);
    check_eq("after_tmo_dig",  r_dig, SEED);
    gval = (base < gq.size()) ? gq[base] : 4'h0;
    check_eq("tmo_first_gnt", 64'(gval), 64'h8);
    gval = (base + 1 < gq.size()) ? gq[base + 1] : 4'h0;
    check_eq("tmo_next_gnt", 64'(gval), 64'h1);
    @(negedge clk);
    bus.req[0]      = 1'b0;
    bus.req_last[0] = 1'b0;

    // Source 1 stalls for 5 cycles in the middle of a 6-byte message.
    for (int i = 0; i < 6; i++) msg[i] = 8'(i + 1);
    b_rdy = rdy_cnt[1];
    run_session(1, 6, 3, 5);
    check_eq("stall_resp_vec",  64'(r_vec), 64'h2);
    check_eq("stall_resp_err",  64'(r_err), 64'h0);
    check_eq("stall_ready_cnt", 64'(rdy_cnt[1] - b_rdy), 64'd6);
    check_eq("stall_digest",    r_dig, model_digest(6));
    check_eq("stall_digest_hi", 64'(r_dig[63:32]), 64'h0607_A5BA);

    // Reset lands while source 2 is streaming.
    b_resp = resp_cnt;
    @(negedge clk);
    bus.req[2] = 1'b1;
    wait_gnt(2, 100, ok);
    check_eq("rst_gnt_seen", 64'(ok), 64'd1);
    @(negedge clk);
    bus.req_byte[2]  = 8'h55;
    bus.req_valid[2] = 1'b1;
    b_rdy = rdy_cnt[2];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy_cnt[2] >= b_rdy + 2) break;
    end
    check_eq("rst_bytes_before", 64'(rdy_cnt[2] - b_rdy), 64'd2);
    reset     = 1'b1;
    bus.req   = '0;
    bus.req_valid = '0;
    @(negedge clk);
    #4;
    check_idle_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_resp", 64'(resp_cnt - b_resp), 64'd0);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_session(0, 3, -1, 0);
    check_eq("post_rst_vec", 64'(r_vec), 64'h1);
    check_eq("post_rst_err", 64'(r_err), 64'h0);
    check_eq("post_rst_dig", r_dig, model_digest(3));
    check_eq("onehot_viol_all", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
